// File: rtl/seed_key_sched_if.sv
// Key-schedule bus: start/key load, G-function operand/result, and the
// round-key valid/ready handoff. The sequencer takes the slave side.
interface seed_key_sched_if;
  logic         start;
  logic [127:0] key;
  logic [31:0]  g_in;
  logic [31:0]  g_out;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   key_idx;
  logic [31:0]  key0;
  logic [31:0]  key1;
  logic         busy;
  logic         done;

  modport master (
    output start, key, g_out, key_ready,
    input  g_in, key_valid, key_idx, key0, key1, busy, done
  );

  modport slave (
    input  start, key, g_out, key_ready,
    output g_in, key_valid, key_idx, key0, key1, busy, done
  );
endinterface

// File: rtl/seed_key_sched.sv
// SEED-128 key-schedule sequencer. Derives ROUNDS round-key pairs from a
// 128-bit user key using one shared external G function, evaluated twice per
// round, and hands each pair out over a valid/ready handshake.
// Optional build macro SEED_KS_GREG_EN: the G path is treated as registered,
// so each G evaluation gets a wait state and i_G_Out is taken at its end.
module seed_key_sched #(
  parameter logic [31:0] KC_INIT = 32'h9E3779B9,
  parameter int unsigned ROUNDS  = 16
) (
  input logic            clk,
  input logic            rst,
  seed_key_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    G0   = 3'd1,
    G0W  = 3'd2,
    G1   = 3'd3,
    G1W  = 3'd4,
    OUT  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_t      state;
  state_t      next;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic [31:0] d;
  logic [31:0] kc;
  logic [3:0]  idx;
  logic [31:0] key0_q;
  logic [31:0] key1_q;
  logic        cap0;
  logic        cap1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next-state, G operand and handshake outputs
  always_comb begin
    next          = state;
    bus.g_in      = '0;
    bus.key_valid = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = 1'b1;
    cap0          = 1'b0;
    cap1          = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) next = G0;
      end
      G0: begin
        bus.g_in = a + c - kc;
`ifdef SEED_KS_GREG_EN
        next = G0W;
`else
        cap0 = 1'b1;
        next = G1;
`endif
      end
      G0W: begin
        bus.g_in = a + c - kc;
        cap0     = 1'b1;
        next     = G1;
      end
      G1: begin
        bus.g_in = b - d + kc;
`ifdef SEED_KS_GREG_EN
        next = G1W;
`else
        cap1 = 1'b1;
        next = OUT;
`endif
      end
      G1W: begin
        bus.g_in = b - d + kc;
        cap1     = 1'b1;
        next     = OUT;
      end
      OUT: begin
        bus.key_valid = 1'b1;
        if (bus.key_ready) next = (idx == LAST_IDX) ? DONE : G0;
      end
      DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Key halves, round constant, round index and captured G results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a      <= '0;
      b      <= '0;
      c      <= '0;
      d      <= '0;
      kc     <= '0;
      idx    <= '0;
      key0_q <= '0;
      key1_q <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        a   <= bus.key[127:96];
        b   <= bus.key[95:64];
        c   <= bus.key[63:32];
        d   <= bus.key[31:0];
        kc  <= KC_INIT;
        idx <= '0;
      end
      if (cap0) key0_q <= bus.g_out;
      if (cap1) key1_q <= bus.g_out;
      if (state == OUT && bus.key_ready) begin
        // Round parity is idx[0]: even idx rotates {A,B} right, odd rotates {C,D} left.
        if (!idx[0]) begin
          a <= {b[7:0], a[31:8]};
          b <= {a[7:0], b[31:8]};
        end else begin
          c <= {c[23:0], d[31:24]};
          d <= {d[23:0], c[31:24]};
        end
        kc  <= {kc[30:0], kc[31]};
        idx <= idx + 4'd1;
      end
    end
  end

  assign bus.key_idx = idx;
  assign bus.key0    = key0_q;
  assign bus.key1    = key1_q;

endmodule

// File: tb/tb_seed_key_sched.sv
// Self-checking bench for seed_key_sched: directed and random keys against a
// software key-schedule model, with backpressure, start-while-busy,
// start-during-DONE and mid-run reset. Honours SEED_KS_GREG_EN for the G stub.
module tb_seed_key_sched;

  localparam int ROUNDS = 16;
  localparam logic [31:0] KC0 = 32'h9E3779B9;
`ifdef SEED_KS_GREG_EN
  localparam int CPR = 5;
`else
  localparam int CPR = 3;
`endif

  logic clk;
  logic rst;
  int   g_mode;
  int   cyc;
  int   done_cnt;
  int   checks;
  int   failures;

  logic [31:0] exp0 [ROUNDS];
  logic [31:0] exp1 [ROUNDS];
  logic [31:0] obs0 [ROUNDS];
  logic [31:0] obs1 [ROUNDS];

  seed_key_sched_if bus();

  seed_key_sched #(.KC_INIT(KC0), .ROUNDS(ROUNDS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Stand-in G: mode 0 is identity, mode 1 a nonlinear 32-bit mixer.
  function automatic logic [31:0] g_fn(input logic [31:0] x, input int mode);
    logic [31:0] y;
    if (mode == 0) return x;
    y = (x ^ {x[15:0], x[31:16]}) * 32'h2545F491;
    return y ^ {y[12:0], y[31:13]} ^ 32'hA5A50F0F;
  endfunction

`ifdef SEED_KS_GREG_EN
  always @(posedge clk) bus.g_out <= g_fn(bus.g_in, g_mode);
`else
  assign bus.g_out = g_fn(bus.g_in, g_mode);
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  // Key schedule from the rules: 64-bit halves, rotate by 8, KC rotates by 1.
  function automatic void model(input logic [127:0] k);
    logic [63:0] ab, cd;
    logic [31:0] kc;
    ab = k[127:64];
    cd = k[63:0];
    kc = KC0;
    for (int i = 0; i < ROUNDS; i++) begin
      exp0[i] = g_fn(ab[63:32] + cd[63:32] - kc, g_mode);
      exp1[i] = g_fn(ab[31:0] - cd[31:0] + kc, g_mode);
      if (i % 2 == 0) ab = (ab >> 8) | (ab << 56);
      else            cd = (cd << 8) | (cd >> 56);
      kc = (kc << 1) | (kc >> 31);
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " outs_zero"},
          {26'd0, bus.key_valid, bus.busy, bus.done, 1'b0, bus.key_idx},
          64'd0);
    check({tag, " keys_zero"}, {bus.key0, bus.key1}, 64'd0);
    check({tag, " gin_zero"}, {32'd0, bus.g_in}, 64'd0);
  endtask

  // One schedule run. stall/bstart/abort are round indices (-1 = unused);
  // sid requests start during the DONE cycle.
  task automatic run(input logic [127:0] k, input int stall, input int bstart,
                     input int abort, input bit sid, input string tag);
    int t0, n, d0;
    logic [31:0] h0, h1;
    model(k);
    d0 = done_cnt;
    @(negedge clk);
    bus.key   = k;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b0;
    bus.key   = ~k;
    for (int r = 0; r < ROUNDS; r++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.key_valid !== 1'b1 && n < 4 * CPR);
      if (r == 0) check({tag, " first_valid"}, 64'(cyc - t0), 64'(CPR - 1));
      check($sformatf("%s valid r%0d", tag, r), {63'd0, bus.key_valid}, 64'd1);
      check($sformatf("%s idx r%0d", tag, r), {60'd0, bus.key_idx}, 64'(r));
      check($sformatf("%s pair r%0d", tag, r), {bus.key0, bus.key1}, {exp0[r], exp1[r]});
      obs0[r] = bus.key0;
      obs1[r] = bus.key1;
      if (r == abort) begin
        rst = 1'b1;
        #1;
        check_zero({tag, " abort"});
        return;
      end
      if (r == bstart) begin
        bus.key   = ~k ^ 128'h1234;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      if (r == stall) begin
        h0 = bus.key0;
        h1 = bus.key1;
        bus.key_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check($sformatf("%s stall r%0d", tag, r),
                {27'd0, bus.key_valid, bus.key_idx, bus.key0 ^ h0, bus.key1 ^ h1} , {27'd1, 4'(r), 64'd0});
        end
        bus.key_ready = 1'b1;
      end
    end
    @(negedge clk);
    check({tag, " done"}, {62'd0, bus.done, bus.busy}, 64'd2);
    check({tag, " cycles"}, 64'(cyc - t0), 64'(ROUNDS * CPR + (stall >= 0 ? 5 : 0)));
    if (sid) begin
      bus.key   = k;
      bus.start = 1'b1;
    end
    @(negedge clk);
    check({tag, " idle"}, {62'd0, bus.done, bus.busy}, 64'd0);
    check({tag, " done_once"}, 64'(done_cnt - d0), 64'd1);
    if (sid) begin
      @(negedge clk);
      check({tag, " start_after_done"}, {63'd0, bus.busy}, 64'd1);
      bus.start = 1'b0;
      rst = 1'b1;
      #1;
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [127:0] k;
    int d0;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    done_cnt  = 0;
    g_mode    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.key   = '0;
    bus.key_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Identity G, all-zero key.
    run(128'd0, -1, -1, -1, 1'b0, "zero_key");
    check("zero_key k0_idx0", {32'd0, obs0[0]}, 64'h61C88647);
    check("zero_key k1_idx0", {32'd0, obs1[0]}, 64'h9E3779B9);
    check("zero_key k0_idx1", {32'd0, obs0[1]}, 64'hC3910C8D);
    check("zero_key k1_idx1", {32'd0, obs1[1]}, 64'h3C6EF373);

    // Identity G, A=1 B=2 C=3 D=4.
    run({32'd1, 32'd2, 32'd3, 32'd4}, -1, -1, -1, 1'b0, "abcd");
    check("abcd k0_idx0", {32'd0, obs0[0]}, 64'h61C8864B);
    check("abcd k1_idx0", {32'd0, obs1[0]}, 64'h9E3779B7);

    // Nonlinear G, random keys.
    g_mode = 1;
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run(k, -1, -1, -1, 1'b0, $sformatf("rand%0d", i));
    end

    // Backpressure at idx3.
    k = {$urandom, $urandom, $urandom, $urandom};
    run(k, 3, -1, -1, 1'b0, "stall");

    // Start while busy at idx7, reset at idx9, then a clean full run.
    k = {$urandom, $urandom, $urandom, $urandom};
    d0 = done_cnt;
    run(k, -1, 7, 9, 1'b0, "abort");
    repeat (2) @(negedge clk);
    check("abort no_done", 64'(done_cnt - d0), 64'd0);
    check_zero("abort held");
    rst = 1'b0;
    k = {$urandom, $urandom, $urandom, $urandom};
    run(k, -1, -1, -1, 1'b1, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so a stuck design still reaches a verdict.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
